// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface ram_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5
);
   logic                  req0_valid;
   logic                  req0_ready;
   logic                  req0_wr;
   logic [ADDR_WIDTH-1:0] req0_addr;
   logic [DATA_WIDTH-1:0] req0_wdata;
   logic                  rsp0_valid;
   logic [DATA_WIDTH-1:0] rsp0_rdata;

   logic                  req1_valid;
   logic                  req1_ready;
   logic                  req1_wr;
   logic [ADDR_WIDTH-1:0] req1_addr;
   logic [DATA_WIDTH-1:0] req1_wdata;
   logic                  rsp1_valid;
   logic [DATA_WIDTH-1:0] rsp1_rdata;

   logic                  ram_rd_en;
   logic                  ram_wr_en;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_data_in;
   logic [DATA_WIDTH-1:0] ram_data_out;

   modport slave (
      input  req0_valid, req0_wr, req0_addr, req0_wdata,
      input  req1_valid, req1_wr, req1_addr, req1_wdata,
      input  ram_data_out,
      output req0_ready, rsp0_valid, rsp0_rdata,
      output req1_ready, rsp1_valid, rsp1_rdata,
      output ram_rd_en, ram_wr_en, ram_addr, ram_data_in
   );

   modport master (
      output req0_valid, req0_wr, req0_addr, req0_wdata,
      output req1_valid, req1_wr, req1_addr, req1_wdata,
      output ram_data_out,
      input  req0_ready, rsp0_valid, rsp0_rdata,
      input  req1_ready, rsp1_valid, rsp1_rdata,
      input  ram_rd_en, ram_wr_en, ram_addr, ram_data_in
   );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a single-port RAM.
// One RAM operation in flight: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
module ram_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5,
   parameter int RD_LATENCY = 1
) (
   input  logic         clk,
   input  logic         rst,
   ram_arbiter_if.slave bus,
   output logic         busy
);
   localparam int NUM_REQ = 2;
   localparam int CNT_W   = 3;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   typedef struct packed {
      logic                  wr;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } req_t;

   state_t                              state, state_nxt;
   logic   [NUM_REQ-1:0]                req_valid, req_ready, rsp_valid;
   req_t   [NUM_REQ-1:0]                req;
   logic   [NUM_REQ-1:0][DATA_WIDTH-1:0] rsp_rdata;

   logic                  gnt_id, last_grant, cap_id, cap_wr, accept;
   logic [CNT_W-1:0]      cnt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] din_q;

   assign req_valid = {bus.req1_valid, bus.req0_valid};
   assign req[0]    = {bus.req0_wr, bus.req0_addr, bus.req0_wdata};
   assign req[1]    = {bus.req1_wr, bus.req1_addr, bus.req1_wdata};

   assign bus.req0_ready  = req_ready[0];
   assign bus.req1_ready  = req_ready[1];
   assign bus.rsp0_valid  = rsp_valid[0];
   assign bus.rsp1_valid  = rsp_valid[1];
   assign bus.rsp0_rdata  = rsp_rdata[0];
   assign bus.rsp1_rdata  = rsp_rdata[1];
   assign bus.ram_addr    = addr_q;
   assign bus.ram_data_in = din_q;

   // On a tie the requester that was not served last wins.
   always_comb begin
      gnt_id = 1'b0;
      if (&req_valid)        gnt_id = ~last_grant;
      else if (req_valid[1]) gnt_id = 1'b1;
   end

   // Gated by rst so ready drops the moment reset asserts.
   assign accept = rst && (state == IDLE) && (|req_valid);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = ISSUE;
         ISSUE:   state_nxt = cap_wr ? RESP : WAIT;
         WAIT:    if (cnt == CNT_W'(1)) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy          = (state != IDLE);
      bus.ram_rd_en = (state == ISSUE) && !cap_wr;
      bus.ram_wr_en = (state == ISSUE) &&  cap_wr;
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      always_comb begin
         req_ready[i] = accept && (gnt_id == 1'(i));
         rsp_valid[i] = (state == RESP) && (cap_id == 1'(i));
      end
   end

   // RAM pins are loaded at acceptance so they are stable throughout ISSUE
   // and simply hold afterwards.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_wr     <= 1'b0;
         cap_id     <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= '0;
         addr_q     <= '0;
         din_q      <= '0;
         rsp_rdata  <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               cap_wr     <= req[gnt_id].wr;
               cap_id     <= gnt_id;
               last_grant <= gnt_id;
               addr_q     <= req[gnt_id].addr;
               din_q      <= req[gnt_id].wdata;
            end
            ISSUE: begin
               if (cap_wr) rsp_rdata[cap_id] <= '0;
               else        cnt <= CNT_W'(RD_LATENCY);
            end
            WAIT: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) rsp_rdata[cap_id] <= bus.ram_data_out;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the single-port 32x8 RAM.
- Accepts read/write requests over valid/ready handshakes and drives the RAM's rd_en/wr_en/addr/data_in pins.
- Waits out the RAM read latency, then returns read data or a write acknowledgement to the requester that issued the operation.
- Sits between the bus-side masters and the RAM; exactly one RAM operation is in flight at a time.

Parameters:
DATA_WIDTH, 8, RAM data width in bits
ADDR_WIDTH, 5, RAM address width in bits (32 locations)
RD_LATENCY, 1, cycles from the RAM issue cycle to valid ram_data_out; legal range 1..7

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  asynchronous, active-low reset
req0_valid  input  1  requester 0 has a request
req0_ready  output  1  arbiter accepts requester 0 this cycle
req0_wr  input  1  1 = write, 0 = read
req0_addr  input  ADDR_WIDTH  request address
req0_wdata  input  DATA_WIDTH  write data
rsp0_valid  output  1  one-cycle response pulse to requester 0
rsp0_rdata  output  DATA_WIDTH  read data (0 for write ack)
req1_valid, req1_ready, req1_wr, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as requester 0, for requester 1
ram_rd_en  output  1  RAM read enable
ram_wr_en  output  1  RAM write enable
ram_addr  output  ADDR_WIDTH  RAM address
ram_data_in  output  DATA_WIDTH  RAM write data
ram_data_out  input  DATA_WIDTH  RAM read data
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst.
- Reset values (rst=0): state=IDLE, last_grant=1, all ready/valid/enable outputs 0, ram_addr=0, ram_data_in=0, rspN_rdata=0, busy=0, wait counter=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, grant selection: reqN_ready is combinational and is high only for the granted requester.
  - Only one requester valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: both ready outputs 0.
  - At most one ready is high per cycle; ready never depends on ready.
- IDLE, acceptance: on valid&ready, register wr/addr/wdata and the grant ID, update last_grant to that ID, and go to ISSUE. Requests are never dropped while valid is held.
- ISSUE (exactly 1 cycle):
  - Drive ram_addr and ram_data_in from the captured request.
  - Write: ram_wr_en=1, next state RESP.
  - Read: ram_rd_en=1, load the wait counter with RD_LATENCY, next state WAIT.
  - ram_rd_en and ram_wr_en are never high together.
- WAIT:
  - Enables are 0; the counter decrements each cycle.
  - In the cycle the counter reaches 1, ram_data_out is valid. Capture it into the granted requester's rspN_rdata and go to RESP.
  - WAIT therefore lasts RD_LATENCY cycles.
- RESP (exactly 1 cycle):
  - rspN_valid=1 for the granted requester only.
  - Read: rdata holds the captured data. Write: rdata is 0.
  - Next state IDLE.
- rspN_rdata holds its last value outside RESP. The non-granted requester's rdata is untouched.
- ram_addr and ram_data_in hold their last values when enables are 0.
- Latency, from the acceptance edge (cycle A):
  - Write: ISSUE at A+1, rsp pulse at A+2.
  - Read: ISSUE at A+1, rsp pulse at A+2+RD_LATENCY.
  - Next acceptance is possible in the cycle after RESP (write: one op per 3 cycles; read: one op per 3+RD_LATENCY cycles).
- Requests presented while busy see ready=0 and must hold valid.
- No backpressure on responses: the pulse is not repeated.
- Reset asserted mid-operation: the in-flight operation is abandoned, no response is issued, all outputs return to reset values immediately (asynchronous), and the RAM contents are not protected.
- Address and data widths are exact; no truncation or extension is performed.

Test Plan:
- Reset, then requester 0 writes 0xA5 to addr 5 -> ram_wr_en=1 with ram_addr=5 and ram_data_in=0xA5 at A+1; rsp0_valid pulse at A+2 with rsp0_rdata=0; rsp1_valid stays 0.
- Requester 1 reads addr 5 with the RAM model returning 0xA5 (RD_LATENCY=1) -> ram_rd_en=1 at A+1; rsp1_valid=1 with rsp1_rdata=0xA5 at A+3.
- Both requesters hold valid reads continuously from reset -> grants alternate 0,1,0,1 and each ready lasts 1 cycle; never both ready; 4 responses in 16 cycles.
- Only requester 1 valid for 3 consecutive ops -> requester 1 granted every time, no idle slots beyond the FSM; then both valid -> requester 0 granted next.
- RD_LATENCY=3, read addr 31 returning 0x3C -> WAIT lasts 3 cycles; rsp pulse at A+5 with rdata=0x3C.
- rst driven low during WAIT, released 2 cycles later -> all outputs 0 immediately, no rsp pulse, state IDLE; the next request is granted to requester 0 on a tie.
